// File: rtl/ir_cmd_ctrl_if.sv
// Command pop handshake between ir_cmd_ctrl and the register-side consumer.
// master: FIFO head producer; slave: software-facing consumer.
interface ir_cmd_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [12:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/ir_cmd_ctrl.sv
// IR frame -> confirmed key command sequencer with a small pop FIFO.
// Optional held-key auto-repeat events: define IR_REPEAT_EVENT_EN.
module ir_cmd_ctrl #(
    parameter int CONFIRM_CNT   = 2,
    parameter int HOLD_TIMEOUT  = 12000,
    parameter int FIFO_DEPTH    = 4
`ifdef IR_REPEAT_EVENT_EN
    ,
    parameter int REPEAT_PERIOD = 25000
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tick,
    input  logic        enable,
    input  logic        frame_valid,
    input  logic [11:0] frame_code,
    ir_cmd_ctrl_if.master cmd,
    output logic [4:0]  fifo_level,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic [15:0] frame_count,
    output logic [1:0]  state
);

    localparam int TW = $clog2(HOLD_TIMEOUT + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [TW-1:0] HT = TW'(HOLD_TIMEOUT);
    localparam logic [3:0]    CC = 4'(CONFIRM_CNT);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } st_t;

    st_t           st_q, st_n;
    logic [11:0]   key_q, key_n;
    logic [3:0]    match_q, match_n;
    logic [TW-1:0] tmr_q, tmr_n;
    logic          push;
    logic [12:0]   push_data;
    logic          wr_en;
    logic [12:0]   wr_data;

    logic [12:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q;
    logic          ovf_q;
    logic [15:0]   fc_q;
    logic          valid, full, pop, do_push;

    always_comb begin
        st_n      = st_q;
        key_n     = key_q;
        match_n   = match_q;
        tmr_n     = tmr_q;
        push      = 1'b0;
        push_data = {1'b0, key_q};
        if (!enable) begin
            st_n    = IDLE;
            match_n = '0;
            tmr_n   = '0;
        end else if (frame_valid) begin
            // any frame restarts the hold window, even on the timeout cycle
            tmr_n = '0;
            unique case (st_q)
                IDLE: begin
                    key_n   = frame_code;
                    match_n = 4'd1;
                    if (CC == 4'd1) begin
                        push      = 1'b1;
                        push_data = {1'b0, frame_code};
                        st_n      = HELD;
                    end else begin
                        st_n = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (frame_code == key_q) begin
                        match_n = match_q + 4'd1;
                        if (match_n >= CC) begin
                            push = 1'b1;
                            st_n = HELD;
                        end
                    end else begin
                        key_n   = frame_code;
                        match_n = 4'd1;
                    end
                end
                HELD: begin
                    if (frame_code != key_q) begin
                        key_n   = frame_code;
                        match_n = 4'd1;
                        st_n    = CONFIRM;
                    end
                end
                default: st_n = IDLE;
            endcase
        end else if (st_q != IDLE) begin
            if (tmr_q == HT) begin
                st_n    = IDLE;
                tmr_n   = '0;
                match_n = '0;
            end else if (tick) begin
                tmr_n = tmr_q + TW'(1);
            end
        end
    end

`ifdef IR_REPEAT_EVENT_EN
    localparam int RW = $clog2(REPEAT_PERIOD + 1);
    localparam logic [RW-1:0] RP1 = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_q, rpt_n;
    logic          rpt_push;

    // repeat clock runs only while HELD persists; entering HELD restarts it
    always_comb begin
        rpt_n    = '0;
        rpt_push = 1'b0;
        if (st_q == HELD && st_n == HELD) begin
            rpt_n = rpt_q;
            if (tick) begin
                if (rpt_q == RP1) begin
                    rpt_n    = '0;
                    rpt_push = 1'b1;
                end else begin
                    rpt_n = rpt_q + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) rpt_q <= '0;
        else     rpt_q <= rpt_n;
    end

    assign wr_en   = push | rpt_push;
    assign wr_data = rpt_push ? {1'b1, key_q} : push_data;
`else
    assign wr_en   = push;
    assign wr_data = push_data;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q    <= IDLE;
            key_q   <= '0;
            match_q <= '0;
            tmr_q   <= '0;
            fc_q    <= '0;
        end else begin
            st_q    <= st_n;
            key_q   <= key_n;
            match_q <= match_n;
            tmr_q   <= tmr_n;
            if (enable && frame_valid) fc_q <= fc_q + 16'd1;
        end
    end

    assign valid = (level_q != '0);
    assign full  = (level_q == FULL);
    assign pop   = valid & cmd.cmd_ready;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts
    assign do_push = wr_en & (~full | pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_q] <= wr_data;
                wr_q      <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            if (do_push && !pop)
                level_q <= level_q + LW'(1);
            else if (!do_push && pop)
                level_q <= level_q - LW'(1);
            if (wr_en && !do_push) ovf_q <= 1'b1;
            else if (ovf_clr)      ovf_q <= 1'b0;
        end
    end

    assign cmd.cmd_valid = valid;
    assign cmd.cmd_data  = mem[rd_q];
    assign fifo_level    = 5'(level_q);
    assign overflow      = ovf_q;
    assign frame_count   = fc_q;
    assign state         = st_q;

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// Scenario bench for ir_cmd_ctrl: expected commands are queued as frames are
// driven and compared as the consumer pops them.
module tb_ir_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        tick = 1'b1;
    logic        enable = 1'b0;
    logic        frame_valid = 1'b0;
    logic [11:0] frame_code = '0;
    logic        ovf_clr = 1'b0;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] frame_count;
    logic [1:0]  state;

    ir_cmd_ctrl_if cmd_if ();

    ir_cmd_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .tick        (tick),
        .enable      (enable),
        .frame_valid (frame_valid),
        .frame_code  (frame_code),
        .cmd         (cmd_if),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .frame_count (frame_count),
        .state       (state)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad   = 0;
    int          fc    = 0;
    logic [12:0] q[$];

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [11:0] c);
        frame_valid = 1'b1;
        frame_code  = c;
        if (enable) fc++;
        @(posedge CLK);
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic [12:0] exp;
        for (int g = 0; g < 64 && q.size() > 0; g++) begin
            exp = q.pop_front();
            total++;
            if (cmd_if.cmd_valid !== 1'b1) begin
                bad++;
                $display("FAIL %s_valid got=%b exp=1", tag, cmd_if.cmd_valid);
            end else if (cmd_if.cmd_data !== exp) begin
                bad++;
                $display("FAIL %s_data got=%h exp=%h", tag, cmd_if.cmd_data, exp);
            end
            cmd_if.cmd_ready = 1'b1;
            @(posedge CLK);
            #1;
            cmd_if.cmd_ready = 1'b0;
        end
        total++;
        if (fifo_level !== 5'd0) begin
            bad++;
            $display("FAIL %s_empty got=%0d exp=0", tag, fifo_level);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle(3);
        total++;
        if (cmd_if.cmd_valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%b exp=0", cmd_if.cmd_valid);
        end
        total++;
        if (cmd_if.cmd_data !== 13'h0) begin
            bad++; $display("FAIL rst_data got=%h exp=0", cmd_if.cmd_data);
        end
        total++;
        if (fifo_level !== 5'd0) begin
            bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL rst_ovf got=%b exp=0", overflow);
        end
        total++;
        if (frame_count !== 16'd0) begin
            bad++; $display("FAIL rst_fc got=%0d exp=0", frame_count);
        end
        total++;
        if (state !== 2'd0) begin
            bad++; $display("FAIL rst_state got=%0d exp=0", state);
        end
        RST = 1'b0;
        enable = 1'b1;
        idle(1);
    endtask

    task automatic test_confirm();
        send_frame(12'h095);
        total++;
        if (state !== 2'd1 || fifo_level !== 5'd0) begin
            bad++; $display("FAIL conf_first got=%0d/%0d exp=1/0", state, fifo_level);
        end
        idle(4499);
        send_frame(12'h095);
        q.push_back(13'h0095);
        total++;
        if (state !== 2'd2) begin
            bad++; $display("FAIL conf_held got=%0d exp=2", state);
        end
        total++;
        if (fifo_level !== 5'd1) begin
            bad++; $display("FAIL conf_level got=%0d exp=1", fifo_level);
        end
        drain("conf");
    endtask

    task automatic test_enable();
        enable = 1'b0;
        idle(1);
        total++;
        if (state !== 2'd0) begin
            bad++; $display("FAIL en_idle got=%0d exp=0", state);
        end
        send_frame(12'h333);
        total++;
        if (state !== 2'd0 || frame_count !== 16'(fc)) begin
            bad++;
            $display("FAIL en_ignore got=%0d/%0d exp=0/%0d", state, frame_count, fc);
        end
        enable = 1'b1;
    endtask

    task automatic test_mismatch();
        send_frame(12'h095);
        send_frame(12'h0A1);
        total++;
        if (state !== 2'd1 || fifo_level !== 5'd0) begin
            bad++; $display("FAIL mis_conf got=%0d/%0d exp=1/0", state, fifo_level);
        end
        idle(12000);
        total++;
        if (state !== 2'd1) begin
            bad++; $display("FAIL mis_edge got=%0d exp=1", state);
        end
        idle(1);
        total++;
        if (state !== 2'd0 || fifo_level !== 5'd0) begin
            bad++; $display("FAIL mis_tmo got=%0d/%0d exp=0/0", state, fifo_level);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            send_frame(12'h010);
            if (i < 9) idle(4499);
        end
        q.push_back(13'h0010);
`ifdef IR_REPEAT_EVENT_EN
        for (int k = 0; k < 36000 / 25000; k++) q.push_back(13'h1010);
`endif
        total++;
        if (state !== 2'd2) begin
            bad++; $display("FAIL hold_state got=%0d exp=2", state);
        end
        total++;
        if (fifo_level !== 5'(q.size())) begin
            bad++; $display("FAIL hold_level got=%0d exp=%0d", fifo_level, q.size());
        end
        drain("hold");
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 5; k++) begin
            send_frame(12'h101 + 12'(k));
            send_frame(12'h101 + 12'(k));
            if (k < 4) q.push_back(13'h0101 + 13'(k));
        end
        total++;
        if (fifo_level !== 5'd4) begin
            bad++; $display("FAIL ovf_level got=%0d exp=4", fifo_level);
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_set got=%b exp=1", overflow);
        end
        total++;
        if (cmd_if.cmd_data !== 13'h0101) begin
            bad++; $display("FAIL ovf_head got=%h exp=0101", cmd_if.cmd_data);
        end
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_clr got=%b exp=0", overflow);
        end
        send_frame(12'h108);
        ovf_clr = 1'b1;
        send_frame(12'h108);
        ovf_clr = 1'b0;
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_race got=%b exp=1", overflow);
        end
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [12:0] exp;
        send_frame(12'h106);
        exp = q.pop_front();
        total++;
        if (cmd_if.cmd_data !== exp) begin
            bad++; $display("FAIL fp_head got=%h exp=%h", cmd_if.cmd_data, exp);
        end
        q.push_back(13'h0106);
        frame_valid = 1'b1;
        frame_code  = 12'h106;
        cmd_if.cmd_ready = 1'b1;
        fc++;
        @(posedge CLK);
        #1;
        frame_valid = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        total++;
        if (fifo_level !== 5'd4 || overflow !== 1'b0) begin
            bad++; $display("FAIL fp_level got=%0d/%b exp=4/0", fifo_level, overflow);
        end
        drain("fp");
    endtask

    task automatic test_reset_mid();
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        send_frame(12'h201);
        send_frame(12'h201);
        send_frame(12'h202);
        send_frame(12'h202);
        send_frame(12'h203);
        total++;
        if (state !== 2'd1 || fifo_level !== 5'd2) begin
            bad++; $display("FAIL rm_pre got=%0d/%0d exp=1/2", state, fifo_level);
        end
        total++;
        if (frame_count !== 16'(fc)) begin
            bad++; $display("FAIL rm_fc got=%0d exp=%0d", frame_count, fc);
        end
        RST = 1'b1;
        #2;
        total++;
        if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== 5'd0) begin
            bad++;
            $display("FAIL rm_fifo got=%b/%0d exp=0/0", cmd_if.cmd_valid, fifo_level);
        end
        total++;
        if (state !== 2'd0 || frame_count !== 16'd0) begin
            bad++; $display("FAIL rm_state got=%0d/%0d exp=0/0", state, frame_count);
        end
        q.delete();
        fc = 0;
        idle(2);
        RST = 1'b0;
        idle(1);
    endtask

    initial begin
        cmd_if.cmd_ready = 1'b0;
        #1;
        test_reset();
        test_confirm();
        test_enable();
        test_mismatch();
        test_hold();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
